// File: rtl/ref_load_pkg.sv
// Shared types and constants for the reference-memory load streamer.
package ref_load_pkg;

  localparam int unsigned PIX_W         = 8;
  localparam int unsigned PIX_PER_WORD  = 4;
  localparam int unsigned TOTAL_WORDS_C = 768;
  localparam int unsigned CNT_W         = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_KICK,
    ST_DELAY,
    ST_STREAM,
    ST_DONE
  } state_e;

  // States in which upstream words may be accepted
  function automatic logic ingest_phase(input state_e s);
    return (s == ST_PREFILL) || (s == ST_KICK) || (s == ST_DELAY) || (s == ST_STREAM);
  endfunction

endpackage

// File: rtl/ref_load_fifo.sv
// Synchronous FIFO buffering reference words between the fetch path and the emit stage.
module ref_load_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        push_data,
  output logic [DATA_W-1:0]        pop_data_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_nxt_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_c      = (count_q == CW'(DEPTH));
  assign empty_c     = (count_q == '0);
  assign pop_data_c  = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign count_nxt_c = count_d;

  // Push into a full FIFO is dropped even when a pop happens the same cycle
  always_comb begin
    push_ok  = push && !full_c && !flush;
    pop_ok   = pop && !empty_c && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ref_load_stream.sv
// Reference-load feeder: buffers fetched words, kicks the bank write sequencer, then
// streams one word per cycle. Optional REF_LOAD_UFCNT_EN adds the uf_count output.
module ref_load_stream
  import ref_load_pkg::*;
#(
  parameter int unsigned DATA_W      = PIX_W * PIX_PER_WORD,
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned PREFILL     = 48,
  parameter int unsigned TOTAL_WORDS = TOTAL_WORDS_C,
  parameter int unsigned START_DLY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              begin_prepare,
  output logic              wr_valid,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              underflow
`ifdef REF_LOAD_UFCNT_EN
  ,
  output logic [CNT_W-1:0]  uf_count
`endif
);

  localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DLY_W    = (START_DLY > 1) ? $clog2(START_DLY) : 1;
  localparam int unsigned DLY_LAST = (START_DLY > 0) ? START_DLY - 1 : 0;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
  logic               s_ready_q, s_ready_d;
  logic               begin_prepare_q, begin_prepare_d;
  logic               wr_valid_q, wr_valid_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               underflow_q, underflow_d;

  logic               start_ok;
  logic               push, pop, flush;
  logic               fifo_full, fifo_empty;
  logic [DATA_W-1:0]  fifo_pop_data;
  logic [CW-1:0]      fifo_cnt, fifo_cnt_nxt;

  ref_load_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .push        (push),
    .pop         (pop),
    .push_data   (s_data),
    .pop_data_c  (fifo_pop_data),
    .full_c      (fifo_full),
    .empty_c     (fifo_empty),
    .count       (fifo_cnt),
    .count_nxt_c (fifo_cnt_nxt)
  );

  // Next state, counters and registered outputs
  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    dly_cnt_d   = dly_cnt_q;
    underflow_d = underflow_q;
    flush       = 1'b0;
    start_ok    = 1'b0;
    push        = s_valid && s_ready_q && !fifo_full;

    if (push) in_cnt_d = in_cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_ok    = 1'b1;
          flush       = 1'b1;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          underflow_d = 1'b0;
          state_d     = ST_PREFILL;
        end
      end
      ST_PREFILL: begin
        if ((fifo_cnt >= CW'(PREFILL)) || (in_cnt_q == CNT_W'(TOTAL_WORDS))) state_d = ST_KICK;
      end
      ST_KICK: begin
        dly_cnt_d = '0;
        state_d   = (START_DLY == 0) ? ST_STREAM : ST_DELAY;
      end
      ST_DELAY: begin
        dly_cnt_d = dly_cnt_q + DLY_W'(1);
        if (dly_cnt_q == DLY_W'(DLY_LAST)) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (out_cnt_q == CNT_W'(TOTAL_WORDS)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Word for the next emit cycle is popped one cycle ahead into wr_data_q
    pop = (state_d == ST_STREAM);
    if (pop) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
      if (fifo_empty) underflow_d = 1'b1;
    end

    wr_valid_d      = pop;
    wr_data_d       = (pop && !fifo_empty) ? fifo_pop_data : '0;
    begin_prepare_d = (state_d == ST_KICK);
    done_d          = (state_d == ST_DONE);
    busy_d          = (state_d != ST_IDLE);
    s_ready_d       = ingest_phase(state_d) && (fifo_cnt_nxt < CW'(FIFO_DEPTH)) &&
                      (in_cnt_d < CNT_W'(TOTAL_WORDS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      in_cnt_q        <= '0;
      out_cnt_q       <= '0;
      dly_cnt_q       <= '0;
      s_ready_q       <= 1'b0;
      begin_prepare_q <= 1'b0;
      wr_valid_q      <= 1'b0;
      wr_data_q       <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      underflow_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      in_cnt_q        <= in_cnt_d;
      out_cnt_q       <= out_cnt_d;
      dly_cnt_q       <= dly_cnt_d;
      s_ready_q       <= s_ready_d;
      begin_prepare_q <= begin_prepare_d;
      wr_valid_q      <= wr_valid_d;
      wr_data_q       <= wr_data_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      underflow_q     <= underflow_d;
    end
  end

  assign s_ready       = s_ready_q;
  assign begin_prepare = begin_prepare_q;
  assign wr_valid      = wr_valid_q;
  assign wr_data       = wr_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign underflow     = underflow_q;

`ifdef REF_LOAD_UFCNT_EN
  logic [CNT_W-1:0] uf_count_q, uf_count_d;

  // Saturating count of zero-data emits in the current load
  always_comb begin
    uf_count_d = uf_count_q;
    if (start_ok) uf_count_d = '0;
    else if (pop && fifo_empty && (uf_count_q != '1)) uf_count_d = uf_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) uf_count_q <= '0;
    else     uf_count_q <= uf_count_d;
  end

  assign uf_count = uf_count_q;
`endif

endmodule
